// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between fetch and data ports.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, WAIT} state_t;
    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);
    state_t state, state_nx;
    logic [1:0] lat_cnt;
    logic last_grant;
    logic ireq, dreq, pick_d, done;
    always_comb begin
        // the port being acknowledged this cycle still holds the same request
        ireq = if_req & ~if_ready;
        dreq = d_req & ~d_ready;
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = dreq & (~ireq | ~last_grant);
`else
        pick_d = dreq;
`endif
        done = state == WAIT && lat_cnt == 2'd0;
        state_nx = state == IDLE ? (pick_d ? GNT_D : ireq ? GNT_IF : IDLE) :
                   state == WAIT ? (done ? IDLE : WAIT) : WAIT;
        mem_en = state == GNT_IF || state == GNT_D;
        mem_addr = state == GNT_D ? d_addr : state == GNT_IF ? if_addr : '0;
        mem_we = state == GNT_D ? d_we : '0;
        mem_wdata = state == GNT_D ? d_wdata : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lat_cnt <= 2'd0;
            last_grant <= 1'b1;
            if_ready <= 1'b0;
            d_ready <= 1'b0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (ireq || dreq))
                last_grant <= pick_d;
            if (mem_en)
                lat_cnt <= LAT_INIT;
            else if (state == WAIT && !done)
                lat_cnt <= lat_cnt - 2'd1;
            if (done && !last_grant)
                if_rdata <= mem_rdata;
            if (done && last_grant)
                d_rdata <= mem_rdata;
            if_ready <= done & ~last_grant;
            d_ready <= done & last_grant;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with MEM_LAT=1 and MEM_LAT=3 instances.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_if_req = 0, a_d_req = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic [3:0]  a_d_we = 0;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_if_ready, a_d_ready, a_mem_en;
    logic [3:0]  a_mem_we;

    logic        b_d_req = 0;
    logic [31:0] b_d_addr = 0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ready, b_d_ready, b_mem_en;
    logic [3:0]  b_mem_we;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_ready(a_d_ready),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'h0), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .d_req(b_d_req), .d_we(4'h0), .d_addr(b_d_addr), .d_wdata(32'h0),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // RAM A: one-cycle synchronous RAM with byte writes, read-before-write
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    always @(posedge clk) begin
        if (a_mem_en) begin
            a_mem_rdata <= ram[a_mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (a_mem_we[b]) ram[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
        end
    end

    // RAM B: data valid exactly three cycles after mem_en, zero otherwise
    logic [31:0] bp [3];
    always @(posedge clk) begin
        bp[0] <= b_mem_en ? (b_mem_addr ^ 32'h5A5A_0000) : 32'h0;
        bp[1] <= bp[0];
        bp[2] <= bp[1];
    end
    assign b_mem_rdata = bp[2];

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    int b_en_cnt = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_we;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_mem_en) begin
                en_cnt++;
                last_addr = a_mem_addr;
                last_we = a_mem_we;
                last_wdata = a_mem_wdata;
            end
            if (b_mem_en) b_en_cnt++;
            if (a_if_ready || a_d_ready) begin
                check("both_ready", 64'(a_if_ready & a_d_ready), 0);
                check("sb_nonempty", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("port", 64'(a_d_ready), 64'(e.is_d));
                    if (e.chk) check("rdata", a_d_ready ? a_d_rdata : a_if_rdata, 64'(e.data));
                end
            end
        end
    end

    task automatic single(input logic is_d, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        exp_t e;
        int e0, t;
        e.is_d = is_d;
        e.chk = !(is_d && we != 4'h0);
        e.data = ref_mem[widx(addr)];
        if (is_d)
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[widx(addr)][8*b +: 8] = wdata[8*b +: 8];
        sb.push_back(e);
        @(posedge clk); #1;
        e0 = en_cnt;
        if (is_d) begin
            a_d_req = 1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        end else begin
            a_if_req = 1; a_if_addr = addr;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(is_d ? a_d_ready : a_if_ready) && t < 50);
        check("latency", 64'(t - 1), 3);
        check("en_cnt", 64'(en_cnt - e0), 1);
        check("mem_addr", last_addr, addr);
        check("mem_we", last_we, is_d ? we : 4'h0);
        if (is_d && we != 4'h0) check("mem_wdata", last_wdata, wdata);
        @(posedge clk); #1;
        a_if_req = 0; a_d_req = 0; a_d_we = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem"}, {a_mem_en, a_mem_we, a_mem_addr}, 0);
        check({tag, "_rdy"}, {a_if_ready, a_d_ready, a_mem_wdata}, 0);
        check({tag, "_rdata"}, {a_if_rdata, a_d_rdata}, 0);
        check({tag, "_b"}, {b_d_ready, b_mem_en, b_d_rdata}, 0);
    endtask

    initial begin
        exp_t e;
        logic first_d;
        int ni, nd, t, e0, seen;
        for (int i = 0; i < 256; i++) begin
            ram[i] = (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0F00;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0F00;
        end
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 0;

        // both ports request together and stay busy for four accesses each
`ifdef ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        for (int k = 0; k < 8; k++) begin
            e.is_d = (k % 2 == 0) ? first_d : !first_d;
            e.chk = 1'b1;
            e.data = ref_mem[widx(e.is_d ? 32'h300 + 32'(4 * (k / 2)) : 32'h200 + 32'(4 * (k / 2)))];
            sb.push_back(e);
        end
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 32'h200;
        a_d_req = 1; a_d_addr = 32'h300; a_d_we = 0;
        ni = 0; nd = 0; t = 0;
        while ((ni < 4 || nd < 4) && t < 200) begin
            @(negedge clk);
            t++;
            if (a_if_ready) ni++;
            if (a_d_ready) nd++;
            @(posedge clk); #1;
            if (ni == 4) a_if_req = 0; else a_if_addr = 32'h200 + 32'(4 * ni);
            if (nd == 4) a_d_req = 0; else a_d_addr = 32'h300 + 32'(4 * nd);
        end
        check("cont_if", 64'(ni), 4);
        check("cont_d", 64'(nd), 4);
        a_if_req = 0; a_d_req = 0;

        single(1'b0, 4'h0, 32'h40, 32'h0);
        single(1'b1, 4'b0011, 32'h80, 32'hDEAD_BEEF);
        single(1'b1, 4'h0, 32'h80, 32'h0);
        single(1'b1, 4'b1000, 32'h84, 32'h1200_0000);
        single(1'b0, 4'h0, 32'h84, 32'h0);

        // MEM_LAT=3 instance: load latency and single RAM enable
        @(posedge clk); #1;
        e0 = b_en_cnt;
        b_d_req = 1; b_d_addr = 32'h100;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!b_d_ready && t < 50);
        check("b_latency", 64'(t - 1), 5);
        check("b_rdata", b_d_rdata, 32'h0100 ^ 32'h5A5A_0000);
        check("b_en_cnt", 64'(b_en_cnt - e0), 1);
        @(posedge clk); #1 b_d_req = 0;

        // reset during the WAIT cycle of a fetch
        @(posedge clk); #1;
        a_if_req = 1; a_if_addr = 32'h44;
        @(posedge clk); #1;
        check("gnt_en", 64'(a_mem_en), 1);
        @(posedge clk); #1;
        rst = 1;
        #1 check_zero("midrst");
        a_if_req = 0;
        @(posedge clk); #1 rst = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_if_ready || a_d_ready) seen++;
        end
        check("stale_ready", 64'(seen), 0);
        single(1'b0, 4'h0, 32'h44, 32'h0);

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
